// File: rtl/key_press_sequencer_if.sv
// key_press_sequencer_if: button inputs, tick strobe and command outputs.
// slave = sequencer side, master = driver of buttons/tick.
interface key_press_sequencer_if;
  logic tick;
  logic inc_btn;
  logic set_btn;
  logic inc_short;
  logic inc_long;
  logic inc_repeat;
  logic set_pulse;
  logic inc_held;

  modport master (
    output tick, inc_btn, set_btn,
    input  inc_short, inc_long, inc_repeat,
    input  set_pulse, inc_held
  );

  modport slave (
    input  tick, inc_btn, set_btn,
    output inc_short, inc_long, inc_repeat,
    output set_pulse, inc_held
  );
endinterface

// File: rtl/key_press_sequencer.sv
// key_press_sequencer: sync + debounce INC/SET, classify INC short/long,
// emit 1-clk command pulses. Ports: clk, reset (async, active-high),
// bus (slave): tick, inc_btn, set_btn -> inc_short, inc_long, inc_repeat,
// set_pulse, inc_held. Macro KEY_AUTO_REPEAT_EN enables inc_repeat.
module key_press_sequencer #(
  parameter int DEBOUNCE_TICKS = 200,
  parameter int LONG_TICKS     = 10000,
  parameter int REPEAT_TICKS   = 2000
) (
  input logic                  clk,
  input logic                  reset,
  key_press_sequencer_if.slave bus
);
  localparam int MAX_DL = (DEBOUNCE_TICKS > LONG_TICKS) ?
                          DEBOUNCE_TICKS : LONG_TICKS;
  localparam int MAXP   = (MAX_DL > REPEAT_TICKS) ?
                          MAX_DL : REPEAT_TICKS;
  localparam int CW     = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] DEB_M1  = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] LONG_M1 = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_M1  = CW'(REPEAT_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    IDLE, DEB_P, HELD, LONG, DEB_R
  } inc_st_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CW'(1);
  endfunction

  logic inc_s1, inc_s2, set_s1, set_s2;

  inc_st_t       state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          short_q, short_n;
  logic          short_p, long_p;
  logic          inc_short_q, inc_long_q, held_q;

  logic          armed, armed_n;
  logic [CW-1:0] scnt, scnt_n;
  logic          set_p, set_pulse_q;

`ifdef KEY_AUTO_REPEAT_EN
  logic          rep_p, inc_repeat_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_s1 <= 1'b0;
      inc_s2 <= 1'b0;
      set_s1 <= 1'b0;
      set_s2 <= 1'b0;
    end else begin
      inc_s1 <= bus.inc_btn;
      inc_s2 <= inc_s1;
      set_s1 <= bus.set_btn;
      set_s2 <= set_s1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    short_n = short_q;
    short_p = 1'b0;
    long_p  = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
    rep_p   = 1'b0;
`endif
    if (bus.tick) begin
      unique case (state)
        // the accepting tick itself is the first counted high tick
        IDLE: if (inc_s2) begin
          state_n = DEB_P;
          cnt_n   = CW'(1);
        end
        DEB_P: if (!inc_s2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt >= DEB_M1) begin
          state_n = HELD;
          cnt_n   = '0;
        end else begin
          cnt_n = sat_inc(cnt);
        end
        // the releasing tick is the first counted low tick
        HELD: if (!inc_s2) begin
          state_n = DEB_R;
          short_n = 1'b1;
          cnt_n   = CW'(1);
        end else if (cnt >= LONG_M1) begin
          state_n = LONG;
          long_p  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = sat_inc(cnt);
        end
        LONG: if (!inc_s2) begin
          state_n = DEB_R;
          short_n = 1'b0;
          cnt_n   = CW'(1);
        end
`ifdef KEY_AUTO_REPEAT_EN
        else if (cnt >= REP_M1) begin
          rep_p = 1'b1;
          cnt_n = '0;
        end else begin
          cnt_n = sat_inc(cnt);
        end
`endif
        DEB_R: if (inc_s2) begin
          cnt_n = '0;
        end else if (cnt >= DEB_M1) begin
          state_n = IDLE;
          short_p = short_q;
          short_n = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = sat_inc(cnt);
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // armed waits for a stable high run, disarmed for a stable low run
  always_comb begin
    armed_n = armed;
    scnt_n  = scnt;
    set_p   = 1'b0;
    if (bus.tick) begin
      if (set_s2 == armed) begin
        if (scnt >= DEB_M1) begin
          armed_n = ~armed;
          scnt_n  = '0;
          set_p   = armed;
        end else begin
          scnt_n = sat_inc(scnt);
        end
      end else begin
        scnt_n = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      short_q     <= 1'b0;
      inc_short_q <= 1'b0;
      inc_long_q  <= 1'b0;
      held_q      <= 1'b0;
      armed       <= 1'b1;
      scnt        <= '0;
      set_pulse_q <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      short_q     <= short_n;
      inc_short_q <= short_p;
      inc_long_q  <= long_p;
      held_q      <= (state_n == HELD) || (state_n == LONG);
      armed       <= armed_n;
      scnt        <= scnt_n;
      set_pulse_q <= set_p;
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) inc_repeat_q <= 1'b0;
    else       inc_repeat_q <= rep_p;
  end
  assign bus.inc_repeat = inc_repeat_q;
`else
  assign bus.inc_repeat = 1'b0;
`endif

  assign bus.inc_short = inc_short_q;
  assign bus.inc_long  = inc_long_q;
  assign bus.set_pulse = set_pulse_q;
  assign bus.inc_held  = held_q;
endmodule

// File: tb/tb_key_press_sequencer.sv
// tb_key_press_sequencer: directed + random stimulus against a
// run-length reference model of the key press sequencer.
module tb_key_press_sequencer;
  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 5;
`ifdef KEY_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  key_press_sequencer_if kp();

  key_press_sequencer #(
    .DEBOUNCE_TICKS(DEB),
    .LONG_TICKS(LNG),
    .REPEAT_TICKS(REP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(kp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit d1_i, d2_i, d1_s, d2_s;
  bit m_pressed, m_releasing, m_short;
  int m_hi, m_lo, m_held;
  bit s_lvl, s_armed;
  int s_run;
  bit e_short, e_long, e_rep, e_set;

  int c_short, c_long, c_rep, c_set;
  int step_no, held_at, short_at, long_at, rep_at;

  bit ri, rs;
  int ri_left, rs_left;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    d1_i = 0; d2_i = 0; d1_s = 0; d2_s = 0;
    m_pressed = 0; m_releasing = 0; m_short = 0;
    m_hi = 0; m_lo = 0; m_held = 0;
    s_lvl = 0; s_armed = 1; s_run = 0;
  endtask

  task automatic clr_counts();
    c_short = 0; c_long = 0; c_rep = 0; c_set = 0;
    step_no = 0;
    held_at = -1; short_at = -1; long_at = -1; rep_at = -1;
  endtask

  // one tick of the press rules, on synchronized levels
  task automatic model_tick(input bit vi, input bit vs);
    if (m_releasing) begin
      if (vi) m_lo = 0;
      else begin
        m_lo++;
        if (m_lo >= DEB) begin
          e_short = m_short;
          m_releasing = 0;
        end
      end
    end else if (m_pressed) begin
      if (!vi) begin
        m_pressed = 0;
        m_releasing = 1;
        m_lo = 1;
        m_short = (m_held < LNG);
      end else begin
        m_held++;
        if (m_held == LNG) e_long = 1;
        else if (REP_EN && m_held > LNG &&
                 (m_held - LNG) % REP == 0) e_rep = 1;
      end
    end else if (vi) begin
      m_hi++;
      if (m_hi >= DEB) begin
        m_pressed = 1;
        m_held = 0;
        m_hi = 0;
      end
    end else m_hi = 0;

    if (vs == s_lvl) s_run++;
    else begin
      s_lvl = vs;
      s_run = 1;
    end
    if (s_run == DEB) begin
      if (vs && s_armed) begin
        e_set = 1;
        s_armed = 0;
      end else if (!vs) s_armed = 1;
    end
  endtask

  task automatic step(input bit ib, input bit sb, input bit tk);
    kp.inc_btn = ib;
    kp.set_btn = sb;
    kp.tick = tk;
    @(posedge clk);
    e_short = 0; e_long = 0; e_rep = 0; e_set = 0;
    if (tk) model_tick(d2_i, d2_s);
    d2_i = d1_i; d1_i = ib;
    d2_s = d1_s; d1_s = sb;
    #1;
    step_no++;
    chk("inc_short", kp.inc_short, e_short);
    chk("inc_long", kp.inc_long, e_long);
    chk("inc_repeat", kp.inc_repeat, e_rep);
    chk("set_pulse", kp.set_pulse, e_set);
    chk("inc_held", kp.inc_held, m_pressed);
    c_short += int'(kp.inc_short);
    c_long  += int'(kp.inc_long);
    c_rep   += int'(kp.inc_repeat);
    c_set   += int'(kp.set_pulse);
    if (kp.inc_held && held_at < 0) held_at = step_no;
    if (kp.inc_short && short_at < 0) short_at = step_no;
    if (kp.inc_long && long_at < 0) long_at = step_no;
    if (kp.inc_repeat && rep_at < 0) rep_at = step_no;
  endtask

  task automatic run(input bit ib, input bit sb, input int n,
                     input bit tk = 1'b1);
    for (int i = 0; i < n; i++) step(ib, sb, tk);
  endtask

  initial begin
    kp.tick = 1'b0;
    kp.inc_btn = 1'b0;
    kp.set_btn = 1'b0;
    reset = 1'b1;
    model_reset();
    clr_counts();
    #12;
    chk("rst_short", kp.inc_short, 1'b0);
    chk("rst_long", kp.inc_long, 1'b0);
    chk("rst_repeat", kp.inc_repeat, 1'b0);
    chk("rst_set", kp.set_pulse, 1'b0);
    chk("rst_held", kp.inc_held, 1'b0);
    reset = 1'b0;
    run(0, 0, 6);

    // glitch: 3 high ticks
    clr_counts();
    run(1, 0, 3);
    run(0, 0, 10);
    chk_int("glitch_short", c_short, 0);
    chk_int("glitch_long", c_long, 0);
    chk_int("glitch_held_at", held_at, -1);

    // short press: 10 high, then release
    clr_counts();
    run(1, 0, 10);
    run(0, 0, 10);
    chk_int("short_cnt", c_short, 1);
    chk_int("short_long", c_long, 0);
    chk_int("short_rep", c_rep, 0);
    chk_int("short_held_at", held_at, 6);
    chk_int("short_at", short_at, 16);

    // long press: 40 high, then release
    clr_counts();
    run(1, 0, 40);
    run(0, 0, 10);
    chk_int("long_cnt", c_long, 1);
    chk_int("long_at", long_at, 26);
    chk_int("long_rep", c_rep, REP_EN ? 3 : 0);
    chk_int("long_rep_at", rep_at, REP_EN ? 31 : -1);
    chk_int("long_short", c_short, 0);

    // SET bounce then hold, re-arm, second press
    clr_counts();
    run(0, 1, 1);
    run(0, 0, 1);
    run(0, 1, 104);
    chk_int("set_first", c_set, 1);
    run(0, 0, 4);
    run(0, 1, 6);
    run(0, 0, 6);
    chk_int("set_second", c_set, 2);

    // tick gating while in DEB_P
    clr_counts();
    run(1, 0, 4);
    run(1, 0, 50, 1'b0);
    chk_int("gate_held_at", held_at, -1);
    clr_counts();
    run(1, 0, 30);
    chk_int("gate_resume_held", held_at, 2);
    chk_int("gate_long", c_long, 1);

    // async reset while in LONG
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_short", kp.inc_short, 1'b0);
    chk("mid_rst_long", kp.inc_long, 1'b0);
    chk("mid_rst_repeat", kp.inc_repeat, 1'b0);
    chk("mid_rst_set", kp.set_pulse, 1'b0);
    chk("mid_rst_held", kp.inc_held, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    clr_counts();
    run(1, 0, 30);
    chk_int("rst_relong_at", long_at, 26);
    chk_int("rst_relong_cnt", c_long, 1);
    run(0, 0, 10);
    chk_int("rst_noshort", c_short, 0);

    // randomized runs on both buttons with sparse ticks
    ri = 0; rs = 0; ri_left = 0; rs_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ri_left == 0) begin
        ri = ~ri;
        ri_left = int'($urandom_range(1, 40));
      end
      if (rs_left == 0) begin
        rs = ~rs;
        rs_left = int'($urandom_range(1, 12));
      end
      step(ri, rs, $urandom_range(0, 3) != 0);
      ri_left--;
      rs_left--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
